// File: rtl/tp_pattern_ctrl.sv
// tp_pattern_ctrl: test-pattern controller between the VGA timing generator and the
// video output path.
//
// Watches the generator's vsync/hsync/dval, starts and stops pattern output only on
// frame boundaries (vsync_i rising), picks one of four patterns (manually or by
// auto-cycling every N frames) and drives registered, sync-aligned RGB888 data.
//
// Optional build macro: TP_CROSSHAIR_EN adds a white crosshair overlay at column HACT/2
// and row VACT/2 while pattern output is active. Without it no overlay logic exists.
//
// Ports:
//   px_clk            pixel clock
//   sys_rst           synchronous active-high reset
//   vsync_i           frame-active from timing generator (rising edge = frame boundary)
//   hsync_i           line sync from timing generator
//   dval_i            active-pixel strobe from timing generator
//   start_i           1-cycle pulse: arm pattern output at the next frame boundary
//   stop_i            1-cycle pulse: stop after the current frame (wins over start_i)
//   auto_en_i         1 = auto-cycle patterns, 0 = manual (mode_sel_i)
//   mode_sel_i        manual pattern id
//   frames_per_pat_i  frames per pattern in auto mode (0 behaves as 1)
//   vsync_o/hsync_o/dval_o  inputs delayed by exactly one cycle
//   rdata_o/gdata_o/bdata_o pixel data aligned with dval_o
//   busy_o            high while waiting for a frame, running or stop-pending
//   pat_id_o          pattern currently displayed
//   frame_cnt_o       frames started in RUN (wraps)
//   frame_start_o     1-cycle pulse at each frame boundary that starts a RUN frame

module tp_pattern_ctrl #(
  parameter int unsigned HACT       = 640,
  parameter int unsigned VACT       = 480,
  parameter int unsigned CHECK_LOG2 = 5
) (
  input  logic        px_clk,
  input  logic        sys_rst,
  input  logic        vsync_i,
  input  logic        hsync_i,
  input  logic        dval_i,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic        auto_en_i,
  input  logic [1:0]  mode_sel_i,
  input  logic [7:0]  frames_per_pat_i,
  output logic        vsync_o,
  output logic        hsync_o,
  output logic        dval_o,
  output logic [7:0]  rdata_o,
  output logic [7:0]  gdata_o,
  output logic [7:0]  bdata_o,
  output logic        busy_o,
  output logic [1:0]  pat_id_o,
  output logic [15:0] frame_cnt_o,
  output logic        frame_start_o
);

  localparam int unsigned BarW = HACT / 8;

  // Bar colours left to right: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [23:0] BarColor [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  typedef enum logic [1:0] {
    StIdle,
    StWaitFrame,
    StRun,
    StStopPend
  } state_e;

  state_e      state_q, state_d;
  logic        vs_edge_q;
  logic        vsync_q, hsync_q, dval_q;
  logic [15:0] x_q, y_q;
  logic [1:0]  pat_id_q, pat_id_d;
  logic [7:0]  ppc_q, ppc_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        frame_start_q, frame_start_d;
  logic [23:0] rgb_q, rgb_d;

  logic        fb;
  logic        active;
  logic [8:0]  ppc_inc;
  logic [8:0]  fpp_eff;

  // Edge register resets high so a vsync_i already high at reset release is not an edge.
  assign fb      = vsync_i & ~vs_edge_q;
  assign active  = (state_q == StRun) || (state_q == StStopPend);
  assign ppc_inc = {1'b0, ppc_q} + 9'd1;
  assign fpp_eff = (frames_per_pat_i == 8'd0) ? 9'd1 : {1'b0, frames_per_pat_i};

  // State machine and per-frame pattern load.
  always_comb begin
    state_d       = state_q;
    pat_id_d      = pat_id_q;
    ppc_d         = ppc_q;
    frame_cnt_d   = frame_cnt_q;
    frame_start_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i && !stop_i) begin
          state_d = StWaitFrame;
        end
      end
      StWaitFrame: begin
        if (stop_i) begin
          state_d = StIdle;
        end else if (fb) begin
          state_d       = StRun;
          ppc_d         = 8'd0;
          pat_id_d      = auto_en_i ? pat_id_q : mode_sel_i;
          frame_cnt_d   = frame_cnt_q + 16'd1;
          frame_start_d = 1'b1;
        end
      end
      StRun: begin
        if (stop_i) begin
          state_d = StStopPend;
        end
        // A boundary coinciding with stop_i still starts that frame; the next one ends it.
        if (fb) begin
          frame_cnt_d   = frame_cnt_q + 16'd1;
          frame_start_d = 1'b1;
          if (auto_en_i) begin
            if (ppc_inc >= fpp_eff) begin
              ppc_d    = 8'd0;
              pat_id_d = pat_id_q + 2'd1;
            end else begin
              ppc_d = ppc_inc[7:0];
            end
          end else begin
            pat_id_d = mode_sel_i;
          end
        end
      end
      StStopPend: begin
        if (fb) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pixel generation from the live x/y counters; registered once below.
  always_comb begin
    logic [23:0] pix;
    logic [23:0] bar_rgb;
    logic        bar_found;
    logic [7:0]  ramp;

    bar_rgb   = 24'h0;
    bar_found = 1'b0;
    // Bar index by comparison against bar edges; x >= HACT matches no bar and stays black.
    for (int unsigned i = 0; i < 8; i++) begin
      if (!bar_found && ({16'b0, x_q} < (i + 1) * BarW)) begin
        bar_rgb   = BarColor[i[2:0]];
        bar_found = 1'b1;
      end
    end

    ramp = (|x_q[15:10]) ? 8'hFF : x_q[9:2];

    pix = 24'h0;
    unique case (pat_id_q)
      2'd0: pix = 24'h0;
      2'd1: pix = bar_rgb;
      2'd2: pix = {ramp, ramp, ramp};
      2'd3: pix = (x_q[CHECK_LOG2] ^ y_q[CHECK_LOG2]) ? 24'hFFFFFF : 24'h0;
      default: pix = 24'h0;
    endcase

`ifdef TP_CROSSHAIR_EN
    if ((x_q == 16'(HACT / 2)) || (y_q == 16'(VACT / 2))) begin
      pix = 24'hFFFFFF;
    end
`endif

    rgb_d = (dval_i && active) ? pix : 24'h0;
  end

  always_ff @(posedge px_clk) begin
    if (sys_rst) begin
      state_q       <= StIdle;
      vs_edge_q     <= 1'b1;
      vsync_q       <= 1'b0;
      hsync_q       <= 1'b0;
      dval_q        <= 1'b0;
      x_q           <= 16'd0;
      y_q           <= 16'd0;
      pat_id_q      <= 2'd0;
      ppc_q         <= 8'd0;
      frame_cnt_q   <= 16'd0;
      frame_start_q <= 1'b0;
      rgb_q         <= 24'h0;
    end else begin
      state_q       <= state_d;
      vs_edge_q     <= vsync_i;
      vsync_q       <= vsync_i;
      hsync_q       <= hsync_i;
      dval_q        <= dval_i;
      pat_id_q      <= pat_id_d;
      ppc_q         <= ppc_d;
      frame_cnt_q   <= frame_cnt_d;
      frame_start_q <= frame_start_d;
      rgb_q         <= rgb_d;

      if (!dval_i) begin
        x_q <= 16'd0;
      end else if (x_q != 16'hFFFF) begin
        x_q <= x_q + 16'd1;
      end

      // dval_q doubles as the previous-cycle dval for line-end detection.
      if (fb) begin
        y_q <= 16'd0;
      end else if (dval_q && !dval_i && (y_q != 16'hFFFF)) begin
        y_q <= y_q + 16'd1;
      end
    end
  end

  assign vsync_o       = vsync_q;
  assign hsync_o       = hsync_q;
  assign dval_o        = dval_q;
  assign rdata_o       = rgb_q[23:16];
  assign gdata_o       = rgb_q[15:8];
  assign bdata_o       = rgb_q[7:0];
  assign busy_o        = (state_q != StIdle);
  assign pat_id_o      = pat_id_q;
  assign frame_cnt_o   = frame_cnt_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_tp_pattern_ctrl.sv
// Scoreboard bench for tp_pattern_ctrl: stimulus pushes expected pixels, frame starts
// and status snapshots into queues; a negedge monitor pops and compares them.

module tb_tp_pattern_ctrl;

  logic        px_clk = 1'b0;
  logic        sys_rst, vsync_i, hsync_i, dval_i, start_i, stop_i, auto_en_i;
  logic [1:0]  mode_sel_i;
  logic [7:0]  frames_per_pat_i;
  logic        vsync_o, hsync_o, dval_o, busy_o, frame_start_o;
  logic [7:0]  rdata_o, gdata_o, bdata_o;
  logic [1:0]  pat_id_o;
  logic [15:0] frame_cnt_o;

  always #5 px_clk = ~px_clk;

  tp_pattern_ctrl dut (
    .px_clk           (px_clk),
    .sys_rst          (sys_rst),
    .vsync_i          (vsync_i),
    .hsync_i          (hsync_i),
    .dval_i           (dval_i),
    .start_i          (start_i),
    .stop_i           (stop_i),
    .auto_en_i        (auto_en_i),
    .mode_sel_i       (mode_sel_i),
    .frames_per_pat_i (frames_per_pat_i),
    .vsync_o          (vsync_o),
    .hsync_o          (hsync_o),
    .dval_o           (dval_o),
    .rdata_o          (rdata_o),
    .gdata_o          (gdata_o),
    .bdata_o          (bdata_o),
    .busy_o           (busy_o),
    .pat_id_o         (pat_id_o),
    .frame_cnt_o      (frame_cnt_o),
    .frame_start_o    (frame_start_o)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  bit          mon_en = 1'b0;
  bit          fin = 1'b0;
  logic [23:0] pix_q [$];
  logic [17:0] fs_q [$];   // {pat_id, frame_cnt}
  logic [18:0] stat_q [$]; // {busy, pat_id, frame_cnt}
  logic [2:0]  exp_sync = 3'b0;

  localparam logic [23:0] Bars [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  function automatic logic [23:0] expv(input int pat, input int x, input int y, input bit on);
    if (!on) return 24'h0;
`ifdef TP_CROSSHAIR_EN
    if (x == 320 || y == 240) return 24'hFFFFFF;
`endif
    case (pat)
      1: begin
        if (x >= 640) return 24'h0;
        return Bars[x / 80];
      end
      2: begin
        if (x > 1023) return 24'hFFFFFF;
        return {3{8'(x >> 2)}};
      end
      3: return ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h0;
      default: return 24'h0;
    endcase
  endfunction

  // ---------------- monitor ----------------
  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge px_clk) exp_sync <= sys_rst ? 3'b000 : {vsync_i, hsync_i, dval_i};

  always @(negedge px_clk) begin
    if (mon_en) begin
      logic [23:0] e;
      logic [17:0] f;
      logic [18:0] s;
      cmp("sync passthrough", {29'b0, vsync_o, hsync_o, dval_o}, {29'b0, exp_sync});
      if (dval_o) begin
        cmp("pixel expected", 32'(pix_q.size() != 0), 32'd1);
        if (pix_q.size() != 0) begin
          e = pix_q.pop_front();
          cmp("rgb", {8'h0, rdata_o, gdata_o, bdata_o}, {8'h0, e});
        end
      end else begin
        cmp("rgb blank", {8'h0, rdata_o, gdata_o, bdata_o}, 32'h0);
      end
      if (frame_start_o) begin
        cmp("frame_start expected", 32'(fs_q.size() != 0), 32'd1);
        if (fs_q.size() != 0) begin
          f = fs_q.pop_front();
          cmp("frame pat_id", {30'b0, pat_id_o}, {30'b0, f[17:16]});
          cmp("frame_cnt", {16'b0, frame_cnt_o}, {16'b0, f[15:0]});
        end
      end
      if (stat_q.size() != 0) begin
        s = stat_q.pop_front();
        cmp("busy", {31'b0, busy_o}, {31'b0, s[18]});
        cmp("status pat_id", {30'b0, pat_id_o}, {30'b0, s[17:16]});
        cmp("status frame_cnt", {16'b0, frame_cnt_o}, {16'b0, s[15:0]});
      end
      if (fin) begin
        cmp("pixels left", 32'(pix_q.size()), 32'd0);
        cmp("frame starts left", 32'(fs_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge px_clk);
    #1;
  endtask

  task automatic stat(input bit busy, input logic [1:0] pat, input logic [15:0] cnt);
    stat_q.push_back({busy, pat, cnt});
  endtask

  // One line: short hsync, npix active pixels, then blanking.
  task automatic line(input int npix, input int y, input int pat, input bit on,
                      input int stop_at, input int rst_at);
    bit on_l = on;
    hsync_i = 1'b1;
    tick();
    hsync_i = 1'b0;
    tick();
    for (int i = 0; i < npix; i++) begin
      dval_i  = 1'b1;
      stop_i  = (i == stop_at);
      sys_rst = (i == rst_at);
      if (i == rst_at) on_l = 1'b0;
      else pix_q.push_back(expv(pat, i, y, on_l));
      tick();
    end
    dval_i  = 1'b0;
    stop_i  = 1'b0;
    sys_rst = 1'b0;
    repeat (3) tick();
  endtask

  task automatic frame_begin(input bit exp_fs, input logic [1:0] pat, input logic [15:0] cnt);
    vsync_i = 1'b0;
    tick();
    tick();
    vsync_i = 1'b1;
    if (exp_fs) fs_q.push_back({pat, cnt});
    tick();
    tick();
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  initial begin
    int auto_pats [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    sys_rst = 1'b1; vsync_i = 1'b1; hsync_i = 1'b0; dval_i = 1'b0;
    start_i = 1'b0; stop_i = 1'b0; auto_en_i = 1'b0;
    mode_sel_i = 2'd1; frames_per_pat_i = 8'd0;
    tick();
    mon_en = 1'b1;
    tick();
    stat(1'b0, 2'd0, 16'd0);
    tick();
    // Release with vsync_i already high: no frame boundary may appear.
    sys_rst = 1'b0;
    tick();
    line(100, 0, 1, 1'b0, -1, -1);
    pulse_start();
    stat(1'b1, 2'd0, 16'd0);
    line(100, 0, 1, 1'b0, -1, -1);

    // Frame 1: colour bars; mid-frame mode change must not apply yet.
    frame_begin(1'b1, 2'd1, 16'd1);
    line(640, 0, 1, 1'b1, -1, -1);
    mode_sel_i = 2'd2;
    line(640, 1, 1, 1'b1, -1, -1);

    // Frame 2: ramp with saturation; start_i while running is ignored.
    frame_begin(1'b1, 2'd2, 16'd2);
    pulse_start();
    line(1030, 0, 2, 1'b1, -1, -1);
    mode_sel_i = 2'd3;

    // Frame 3: checkerboard across the 32-pixel/32-line square edges.
    frame_begin(1'b1, 2'd3, 16'd3);
    for (int y = 0; y < 34; y++) line(64, y, 3, 1'b1, -1, -1);
    mode_sel_i = 2'd0;

    // Frame 4: black pattern, reaching column 320 and row 240.
    frame_begin(1'b1, 2'd0, 16'd4);
    line(330, 0, 0, 1'b1, -1, -1);
    for (int y = 1; y < 240; y++) line(4, y, 0, 1'b1, -1, -1);
    line(8, 240, 0, 1'b1, -1, -1);
    mode_sel_i = 2'd1;

    // Frame 5: stop mid-line; frame completes intact, next boundary ends output.
    frame_begin(1'b1, 2'd1, 16'd5);
    line(640, 0, 1, 1'b1, 300, -1);
    stat(1'b1, 2'd1, 16'd5);
    line(640, 1, 1, 1'b1, -1, -1);
    frame_begin(1'b0, 2'd0, 16'd0);
    stat(1'b0, 2'd1, 16'd5);
    line(100, 0, 1, 1'b0, -1, -1);

    // Simultaneous start and stop from idle: stop wins.
    start_i = 1'b1;
    stop_i  = 1'b1;
    tick();
    start_i = 1'b0;
    stop_i  = 1'b0;
    tick();
    stat(1'b0, 2'd1, 16'd5);
    frame_begin(1'b0, 2'd0, 16'd0);
    line(50, 0, 1, 1'b0, -1, -1);

    // Reset mid-line while running with vsync_i held high across release.
    mode_sel_i = 2'd2;
    pulse_start();
    frame_begin(1'b1, 2'd2, 16'd6);
    line(640, 0, 2, 1'b1, -1, 200);
    stat(1'b0, 2'd0, 16'd0);
    line(100, 1, 2, 1'b0, -1, -1);

    // Auto mode, two frames per pattern, starting from the reset pattern 0.
    auto_en_i        = 1'b1;
    frames_per_pat_i = 8'd2;
    pulse_start();
    stat(1'b1, 2'd0, 16'd0);
    line(20, 2, 0, 1'b0, -1, -1);
    for (int f = 0; f < 9; f++) begin
      frame_begin(1'b1, 2'(auto_pats[f]), 16'(f + 1));
      line(8, 0, auto_pats[f], 1'b1, -1, -1);
    end

    // frames_per_pat_i = 0 behaves as 1: pattern advances every frame.
    frames_per_pat_i = 8'd0;
    for (int f = 0; f < 3; f++) begin
      frame_begin(1'b1, 2'(f + 1), 16'(10 + f));
      line(8, 0, f + 1, 1'b1, -1, -1);
    end
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    frame_begin(1'b0, 2'd0, 16'd0);
    stat(1'b0, 2'd3, 16'd12);
    line(50, 0, 3, 1'b0, -1, -1);

    repeat (4) tick();
    fin = 1'b1;
    repeat (4) tick();
  end

endmodule

// File: doc/tp_pattern_ctrl.md
Name: tp_pattern_ctrl

Overview:
- Test-pattern controller between the VGA timing generator and the video output path.
- Consumes the generator's vsync/hsync/dval and decides when pattern output starts and stops, always on frame boundaries.
- Selects one of four patterns, manually or by auto-cycling every N frames, and produces registered, sync-aligned RGB888 pixel data.

Parameters:
- HACT, 640, active pixels per line; colour-bar width = HACT/8, crosshair column = HACT/2.
- VACT, 480, active lines per frame; crosshair row = VACT/2.
- CHECK_LOG2, 5, checkerboard square size = 2^CHECK_LOG2 pixels.

Ports:
- px_clk  in  1  pixel clock.
- sys_rst  in  1  reset.
- vsync_i  in  1  frame-active from timing generator; rising edge = frame boundary.
- hsync_i  in  1  line sync from timing generator.
- dval_i  in  1  active-pixel strobe from timing generator.
- start_i  in  1  1-cycle pulse: arm pattern output.
- stop_i  in  1  1-cycle pulse: stop after the current frame.
- auto_en_i  in  1  1 = auto-cycle patterns; 0 = manual.
- mode_sel_i  in  2  manual pattern id.
- frames_per_pat_i  in  8  frames per pattern in auto mode; 0 is treated as 1.
- vsync_o, hsync_o, dval_o  out  1 each  inputs delayed exactly 1 cycle.
- rdata_o, gdata_o, bdata_o  out  8 each  pixel data, aligned with dval_o.
- busy_o  out  1  high in WAIT_FRAME, RUN and STOP_PEND.
- pat_id_o  out  2  pattern currently being displayed.
- frame_cnt_o  out  16  frames started in RUN; wraps at 16'hFFFF -> 0.
- frame_start_o  out  1  1-cycle pulse at each frame boundary while in RUN.

Behaviour:
- Clock and reset: single clock px_clk; sys_rst is synchronous, active-high.
- Reset values:
  - All outputs 0; state IDLE; pat_id 0; frame counters 0.
  - x/y counters 0.
  - vsync edge-detect register resets to 1, so a vsync_i already high at reset release does not create a false edge.
- Frame boundary (FB): vsync_i == 1 and registered vsync == 0. x counter: clears when dval_i == 0, increments on each dval_i cycle, saturates at 16'hFFFF. y counter: increments on dval_i falling edge, clears on FB, saturates.
- State machine:
  - IDLE: start_i -> WAIT_FRAME.
  - WAIT_FRAME: FB -> RUN, which loads the pattern and increments frame_cnt. stop_i -> IDLE immediately.
  - RUN: stop_i -> STOP_PEND. A start_i during RUN is ignored.
  - STOP_PEND: next FB -> IDLE. No frame_start_o and no count on that FB.
  - start_i and stop_i in the same cycle: stop wins.
- Pattern load (every FB in RUN, plus the entry into RUN):
  - Manual mode: pat_id <= mode_sel_i. A mode_sel_i change mid-frame has no effect until the next FB.
  - Auto mode: internal per-pattern frame counter increments. On reaching max(frames_per_pat_i, 1), it resets to 0 and pat_id <= pat_id + 1, wrapping 3 -> 0.
  - Entering RUN resets the per-pattern counter to 0. The starting pattern is the current pat_id in auto mode and mode_sel_i in manual mode.
- Patterns (x, y = counters sampled for the current pixel):
  - 0: black, all channels 0.
  - 1: 8 vertical bars of width HACT/8, left to right: white, yellow, cyan, green, magenta, red, blue, black. Bar index is computed by comparison, not division. Pixels with x >= HACT are black.
  - 2: horizontal ramp, R = G = B = x[9:2], saturating to 8'hFF when x > 1023.
  - 3: checkerboard, white if x[CHECK_LOG2] ^ y[CHECK_LOG2], else black.
- Output pipeline and gating:
  - Exactly 1 registered stage; RGB is aligned with dval_o.
  - RGB is forced to 0 when the delayed dval is 0 or the state is not RUN or STOP_PEND.
  - vsync_o, hsync_o and dval_o pass through in every state.
- Reset mid-frame: outputs drop to 0 on the next edge. After release, output waits for a new start_i and then a true FB.

Optional Feature:
- Macro TP_CROSSHAIR_EN.
- Defined: while in RUN or STOP_PEND, pixels with x == HACT/2 or y == VACT/2 are forced to white (8'hFF on all channels), overriding the selected pattern. Still gated by dval.
- Undefined: no overlay logic is synthesised; output is the pure pattern.

Test Plan:
- Reset, then start_i mid-frame with manual mode 1: RGB stays 0 until the next vsync_i rise. Then bar 0 (x 0..79) = FF/FF/FF, bar 1 (x 80..159) = FF/FF/00, and x = 639 = 00/00/00. frame_cnt_o = 1 and frame_start_o pulses once.
- Auto mode, frames_per_pat_i = 2: pat_id_o sequence over 8 frames is 0,0,1,1,2,2,3,3, then 0 on frame 9. With frames_per_pat_i = 0, pat_id_o changes every frame.
- stop_i mid-frame in RUN: the current frame completes with the pattern intact. busy_o falls on the next vsync_i rise, with no frame_start_o on that edge. start_i and stop_i in the same cycle from IDLE: state stays IDLE.
- Pattern 2: dval_o-aligned R = G = B sequence 0,0,0,0,1,... reaching 8'h9F at x = 639. Pattern 3 (CHECK_LOG2 = 5): pixel (32,0) is white and pixel (32,32) is black.
- Assert sys_rst for 1 cycle mid-line while running, with vsync_i held high across release: all outputs 0 the next cycle, no false frame boundary, no output until start_i plus a real vsync_i rise.
- Build with TP_CROSSHAIR_EN, pattern 0: only column 320 and row 240 are FF/FF/FF. Build without it: the whole frame is 0.
